mp_chunked_resolver: RTL and testbench

- Parametrised successor to the fixed 512-bit carry-save resolver and conditional-subtract stage of the Montgomery datapath.
- Converts a redundant (sum, carry) pair of WIDTH bits to binary using one CHUNK-bit adder, iterated over WIDTH/CHUNK cycles.
- Optionally applies the final Montgomery correction (subtract modulus if result >= M), or computes a plain A - B.
- Sits between the carry-save accumulator and the output register of the modular multiplier; start/ready/done handshake toward the controller.

---
 rtl/mp_chunked_resolver.sv | 169 ++++++++++++++++
 tb/tb_mp_chunked_resolver.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_chunked_resolver.sv
// Carry-save to binary resolver using one CHUNK-bit adder over WIDTH/CHUNK cycles.
// It can optionally finish with a Montgomery conditional subtract, or compute A - B.
module mp_chunked_resolver #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned CHUNK = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] op_s_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic [WIDTH-1:0] mod_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             reduced_o
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] OpAdd    = 2'b00;
  localparam logic [1:0] OpReduce = 2'b01;
  localparam logic [1:0] OpSub    = 2'b10;

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] s_q, s_d, c_q, c_d, m_q, m_d;
  logic [WIDTH-1:0] work_q, work_d, diff_q, diff_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cy_q, cy_d, c1_q, c1_d;
  logic             carry_q, carry_d, reduced_q, reduced_d;

  logic [CHUNK-1:0] add_a, add_b;
  logic [CHUNK:0]   add_sum;
  logic             last, subtract;
  int unsigned      base;

  // Single shared slice adder; PASS2 reuses it for r - M.
  always_comb begin
    base = 32'(k_q) * CHUNK;
    last = (k_q == KW'(NCH - 1));
    if (state_q == StPass2) begin
      add_a = work_q[base +: CHUNK];
      add_b = ~m_q[base +: CHUNK];
    end else begin
      add_a = s_q[base +: CHUNK];
      add_b = (op_q == OpSub) ? ~c_q[base +: CHUNK] : c_q[base +: CHUNK];
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + (CHUNK + 1)'(cy_q);
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    op_d      = op_q;
    s_d       = s_q;
    c_d       = c_q;
    m_d       = m_q;
    work_d    = work_q;
    diff_d    = diff_q;
    cy_d      = cy_q;
    c1_d      = c1_q;
    result_d  = result_q;
    carry_d   = carry_q;
    reduced_d = reduced_q;
    subtract  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          state_d = StPass1;
          s_d     = op_s_i;
          c_d     = op_c_i;
          m_d     = mod_i;
          op_d    = (mode_i == 2'b11) ? OpAdd : mode_i;
          k_d     = '0;
          cy_d    = (mode_i == OpSub);
        end
      end
      StPass1: begin
        work_d[base +: CHUNK] = add_sum[CHUNK-1:0];
        cy_d = add_sum[CHUNK];
        k_d  = k_q + KW'(1);
        if (last) begin
          k_d = '0;
          if (op_q == OpReduce) begin
            state_d = StPass2;
            c1_d    = add_sum[CHUNK];
            cy_d    = 1'b1;
          end else begin
            state_d   = StDone;
            result_d  = work_d;
            carry_d   = (op_q == OpSub) ? ~add_sum[CHUNK] : add_sum[CHUNK];
            reduced_d = 1'b0;
          end
        end
      end
      StPass2: begin
        diff_d[base +: CHUNK] = add_sum[CHUNK-1:0];
        cy_d = add_sum[CHUNK];
        k_d  = k_q + KW'(1);
        if (last) begin
          // {c1, r} >= M exactly when either pass carried out.
          subtract  = c1_q | add_sum[CHUNK];
          k_d       = '0;
          state_d   = StDone;
          result_d  = subtract ? diff_d : work_q;
          carry_d   = 1'b0;
          reduced_d = subtract;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear_i) begin
      state_d   = StIdle;
      result_d  = result_q;
      carry_d   = carry_q;
      reduced_d = reduced_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      k_q       <= '0;
      op_q      <= '0;
      s_q       <= '0;
      c_q       <= '0;
      m_q       <= '0;
      work_q    <= '0;
      diff_q    <= '0;
      cy_q      <= 1'b0;
      c1_q      <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      reduced_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      op_q      <= op_d;
      s_q       <= s_d;
      c_q       <= c_d;
      m_q       <= m_d;
      work_q    <= work_d;
      diff_q    <= diff_d;
      cy_q      <= cy_d;
      c1_q      <= c1_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      reduced_q <= reduced_d;
    end
  end

  assign ready_o   = (state_q == StIdle) || (state_q == StDone);
  assign done_o    = (state_q == StDone);
  assign result_o  = result_q;
  assign carry_o   = carry_q;
  assign reduced_o = reduced_q;

endmodule

// File: tb/tb_mp_chunked_resolver.sv
// Bench for mp_chunked_resolver: a 16/4 and a 512/128 instance run in lockstep on shared controls,
// checked every cycle against an arithmetic reference and a few literal results.
module tb_mp_chunked_resolver;

  localparam int NW  = 16;
  localparam int WW  = 512;
  localparam int NCH = 4;
  localparam int NR  = 400;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [1:0]        mode_i = 2'b00;
  logic [NW-1:0]     n_s = '0, n_c = '0, n_m = '0;
  logic [WW-1:0]     w_s = '0, w_c = '0, w_m = '0;
  logic              n_ready, n_done, n_carry, n_red;
  logic              w_ready, w_done, w_carry, w_red;
  logic [NW-1:0]     n_res;
  logic [WW-1:0]     w_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mp_chunked_resolver #(.WIDTH(NW), .CHUNK(4)) u_narrow (
    .clk(clk), .resetn(resetn), .start_i(start_i), .mode_i(mode_i),
    .op_s_i(n_s), .op_c_i(n_c), .mod_i(n_m), .clear_i(clear_i),
    .ready_o(n_ready), .done_o(n_done), .result_o(n_res), .carry_o(n_carry),
    .reduced_o(n_red)
  );

  mp_chunked_resolver #(.WIDTH(WW), .CHUNK(128)) u_wide (
    .clk(clk), .resetn(resetn), .start_i(start_i), .mode_i(mode_i),
    .op_s_i(w_s), .op_c_i(w_c), .mod_i(w_m), .clear_i(clear_i),
    .ready_o(w_ready), .done_o(w_done), .result_o(w_res), .carry_o(w_carry),
    .reduced_o(w_red)
  );

  // Returns {reduced, carry, result} from plain integer arithmetic on w-bit operands.
  function automatic logic [513:0] ref_fn(input logic [1:0] md, input logic [511:0] s,
                                          input logic [511:0] c, input logic [511:0] m,
                                          input int w);
    logic [513:0] mask, sum, r;
    logic cy, red;
    mask = (514'd1 << w) - 514'd1;
    sum  = {2'b00, s} + {2'b00, c};
    cy   = 1'b0;
    red  = 1'b0;
    case (md)
      2'b10: begin
        r  = ({2'b00, s} - {2'b00, c}) & mask;
        cy = (s < c);
      end
      2'b01: begin
        if (sum >= {2'b00, m}) begin
          r   = (sum - {2'b00, m}) & mask;
          red = 1'b1;
        end else begin
          r = sum & mask;
        end
      end
      default: begin
        r  = sum & mask;
        cy = sum[w];
      end
    endcase
    return {red, cy, r[511:0]};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] below(input logic [511:0] x, input logic [511:0] m);
    return (x >= m) ? x - m : x;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: a pending job finishes a fixed number of edges after accept.
  logic         m_pend = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt = 0;
  logic [513:0] p_n = '0, p_w = '0, h_n = '0, h_w = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      p_n    <= '0;
      p_w    <= '0;
      h_n    <= '0;
      h_w    <= '0;
    end else begin
      m_done <= 1'b0;
      if (clear_i) begin
        m_pend <= 1'b0;
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          h_n    <= p_n;
          h_w    <= p_w;
          m_done <= 1'b1;
          m_pend <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (start_i) begin
        m_pend <= 1'b1;
        m_cnt  <= (mode_i == 2'b01) ? 2 * NCH : NCH;
        p_n    <= ref_fn(mode_i, {496'd0, n_s}, {496'd0, n_c}, {496'd0, n_m}, NW);
        p_w    <= ref_fn(mode_i, w_s, w_c, w_m, WW);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      check("n_ready", 512'(n_ready), 512'(!m_pend));
      check("n_done", 512'(n_done), 512'(m_done));
      check("n_result", 512'(n_res), 512'(h_n[NW-1:0]));
      check("n_carry", 512'(n_carry), 512'(h_n[512]));
      check("n_reduced", 512'(n_red), 512'(h_n[513]));
      check("w_ready", 512'(w_ready), 512'(!m_pend));
      check("w_done", 512'(w_done), 512'(m_done));
      check("w_result", w_res, h_w[511:0]);
      check("w_carry", 512'(w_carry), 512'(h_w[512]));
      check("w_reduced", 512'(w_red), 512'(h_w[513]));
    end
  end

  task automatic scramble();
    n_s = 16'($urandom);
    n_c = 16'($urandom);
    n_m = 16'($urandom);
    w_s = rand512();
    w_c = rand512();
    w_m = rand512();
  endtask

  task automatic load(input logic [1:0] md, input logic [15:0] s, input logic [15:0] c,
                      input logic [15:0] m);
    mode_i = md;
    n_s    = s;
    n_c    = c;
    n_m    = m;
    w_m    = rand512() | {1'b1, 511'd0};
    w_s    = rand512();
    w_c    = rand512();
    if (md == 2'b01) begin
      w_s = below(w_s, w_m);
      w_c = below(w_c, w_m);
    end
  endtask

  // Presents one request for one edge, then scrambles the operand inputs.
  task automatic issue(input logic [1:0] md, input logic [15:0] s, input logic [15:0] c,
                       input logic [15:0] m);
    @(negedge clk);
    start_i = 1'b1;
    load(md, s, c, m);
    @(negedge clk);
    start_i = 1'b0;
    scramble();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!n_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", 512'(cyc < 40), 512'(1));
  endtask

  task automatic rand_narrow(input logic [1:0] md, output logic [15:0] s,
                             output logic [15:0] c, output logic [15:0] m);
    m = 16'($urandom) | 16'h8000;
    s = 16'($urandom);
    c = 16'($urandom);
    if (md == 2'b01) begin
      s = (s >= m) ? s - m : s;
      c = (c >= m) ? c - m : c;
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [15:0] rs, rc, rm;

    repeat (3) @(negedge clk);
    check("rst_result", 512'(n_res), 512'(0));
    check("rst_ready", 512'(n_ready), 512'(1));
    check("rst_done", 512'(n_done), 512'(0));
    check("rst_carry", 512'(n_carry), 512'(0));
    check("rst_reduced", 512'(n_red), 512'(0));
    check("rst_w_result", w_res, 512'(0));
    resetn = 1'b1;
    @(negedge clk);

    issue(2'b00, 16'hFFFF, 16'h0001, 16'h0000);
    check("add_busy", 512'(n_ready), 512'(0));
    wait_done(cyc);
    check("add_latency", 512'(cyc), 512'(4));
    check("add_result", 512'(n_res), 512'(16'h0000));
    check("add_carry", 512'(n_carry), 512'(1));
    check("add_reduced", 512'(n_red), 512'(0));

    issue(2'b01, 16'h8000, 16'h0003, 16'h8001);
    wait_done(cyc);
    check("red_latency", 512'(cyc), 512'(8));
    check("red_result", 512'(n_res), 512'(16'h0002));
    check("red_reduced", 512'(n_red), 512'(1));

    issue(2'b01, 16'h1234, 16'h0000, 16'h8001);
    wait_done(cyc);
    check("red_nosub_result", 512'(n_res), 512'(16'h1234));
    check("red_nosub_reduced", 512'(n_red), 512'(0));

    issue(2'b01, 16'hFFFF, 16'h0003, 16'hFFF0);
    wait_done(cyc);
    check("red_ovf_result", 512'(n_res), 512'(16'h0012));
    check("red_ovf_reduced", 512'(n_red), 512'(1));
    check("red_ovf_carry", 512'(n_carry), 512'(0));

    issue(2'b10, 16'h0005, 16'h0007, 16'h0000);
    wait_done(cyc);
    check("sub_latency", 512'(cyc), 512'(4));
    check("sub_neg_result", 512'(n_res), 512'(16'hFFFE));
    check("sub_neg_carry", 512'(n_carry), 512'(1));

    issue(2'b10, 16'h0007, 16'h0005, 16'h0000);
    wait_done(cyc);
    check("sub_pos_result", 512'(n_res), 512'(16'h0002));
    check("sub_pos_carry", 512'(n_carry), 512'(0));

    // Back-to-back: start stays high; the SUB is taken in the DONE cycle of the ADD.
    @(negedge clk);
    start_i = 1'b1;
    load(2'b00, 16'hFFFF, 16'h0001, 16'h0000);
    @(negedge clk);
    wait_done(cyc);
    check("b2b_add_result", 512'(n_res), 512'(16'h0000));
    check("b2b_add_carry", 512'(n_carry), 512'(1));
    load(2'b10, 16'h0005, 16'h0007, 16'h0000);
    @(negedge clk);
    start_i = 1'b0;
    scramble();
    wait_done(cyc);
    check("b2b_sub_latency", 512'(cyc), 512'(4));
    check("b2b_sub_result", 512'(n_res), 512'(16'hFFFE));
    check("b2b_sub_carry", 512'(n_carry), 512'(1));

    // Abort by clear sampled at E2.
    issue(2'b01, 16'h8000, 16'h0003, 16'h8001);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clr_ready", 512'(n_ready), 512'(1));
    pulses = 0;
    repeat (12) begin
      if (n_done) pulses++;
      @(negedge clk);
    end
    check("clr_no_done", 512'(pulses), 512'(0));
    check("clr_result_held", 512'(n_res), 512'(16'hFFFE));

    // Abort by reset just before E5.
    issue(2'b01, 16'h8000, 16'h0003, 16'h8001);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rstmid_result", 512'(n_res), 512'(0));
    check("rstmid_w_result", w_res, 512'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rstmid_ready", 512'(n_ready), 512'(1));
    pulses = 0;
    repeat (10) begin
      if (n_done) pulses++;
      @(negedge clk);
    end
    check("rstmid_no_done", 512'(pulses), 512'(0));

    for (int md = 0; md < 4; md++) begin
      for (int i = 0; i < NR; i++) begin
        rand_narrow(2'(md), rs, rc, rm);
        issue(2'(md), rs, rc, rm);
        if ($urandom_range(15) == 0) begin
          repeat ($urandom_range(6)) @(negedge clk);
          clear_i = 1'b1;
          @(negedge clk);
          clear_i = 1'b0;
        end else begin
          wait_done(cyc);
        end
        repeat ($urandom_range(2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
